// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among N_REQ producers.
// Ports: req/req_data in, gnt/err pulses out, fifo_wr_en/fifo_data_in to FIFO,
//   fifo_full/fifo_wr_ack/fifo_overflow from FIFO, busy/owner_idx status.
module fifo_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int RETRY_MAX  = 3,
  localparam int IW        = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            err,
  output logic                        fifo_wr_en,
  output logic [DATA_WIDTH-1:0]       fifo_data_in,
  input  logic                        fifo_full,
  input  logic                        fifo_wr_ack,
  input  logic                        fifo_overflow,
  output logic                        busy,
  output logic [IW-1:0]               owner_idx
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    ACK,
    BACKOFF
  } state_t;

  state_t                  state_q, state_d;
  logic [N_REQ-1:0]        gnt_q, gnt_d;
  logic [N_REQ-1:0]        err_q, err_d;
  logic                    wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    busy_q, busy_d;
  logic [IW-1:0]           owner_q, owner_d;
  logic [IW-1:0]           rr_q, rr_d;
  logic [3:0]              retry_q, retry_d;

  logic [N_REQ-1:0]        elig;
  logic                    found;
  logic [IW-1:0]           win;

  function automatic logic [IW-1:0] wrap_inc(
    input logic [IW-1:0] v,
    input int            k
  );
    return IW'((int'(v) + k) % N_REQ);
  endfunction

  // The requester pulsed this cycle still holds req; mask it
  // so it cannot win twice in a row off a stale request.
  always_comb begin
    elig  = req & ~(gnt_q | err_q);
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && elig[wrap_inc(rr_q, k)]) begin
        found = 1'b1;
        win   = wrap_inc(rr_q, k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    err_d   = '0;
    wr_en_d = 1'b0;
    data_d  = data_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    retry_d = retry_q;
    unique case (state_q)
      IDLE: begin
        if (found && !fifo_full) begin
          owner_d = win;
          data_d  = req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
          wr_en_d = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = ACK;
      end
      ACK: begin
        if (fifo_wr_ack) begin
          gnt_d[owner_q] = 1'b1;
          rr_d    = wrap_inc(owner_q, 1);
          retry_d = '0;
          state_d = IDLE;
        end else if (fifo_overflow || !fifo_wr_ack) begin
          // overflow and a missing ack both count as a failed try
          if (retry_q + 4'd1 == 4'(RETRY_MAX)) begin
            err_d[owner_q] = 1'b1;
            rr_d    = wrap_inc(owner_q, 1);
            retry_d = '0;
            state_d = IDLE;
          end else begin
            retry_d = retry_q + 4'd1;
            state_d = BACKOFF;
          end
        end
      end
      BACKOFF: begin
        if (!fifo_full) begin
          wr_en_d = 1'b1;
          state_d = WRITE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      err_q   <= '0;
      wr_en_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      owner_q <= '0;
      rr_q    <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      wr_en_q <= wr_en_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      retry_q <= retry_d;
    end
  end

  assign gnt          = gnt_q;
  assign err          = err_q;
  assign fifo_wr_en   = wr_en_q;
  assign fifo_data_in = data_q;
  assign busy         = busy_q;
  assign owner_idx    = owner_q;

endmodule
